// File: rtl/pe2_stage_ctrl.sv
// pe2_stage_ctrl
//   Stage/pair sequencer for the PE2 add/sub/halve unit. Walks one full NTT or
//   INTT pass over a 2^ADDR_W word coefficient memory (Kyber: 7 stages,
//   Dilithium: 8 stages). It issues a pair read every non-stalled RUN cycle,
//   drives the PE2 mode lines, and replays each read as a write-back
//   PIPE_LAT cycles later. A drain gap of PIPE_LAT cycles separates the
//   stages, so the last write of a stage lands before the first read of the
//   next stage.
//
//   Optional build macro: PE2_STAGE_CTRL_CYCLE_CNT_EN adds a 16-bit busy-cycle
//   counter output (cycle_cnt).
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle request, honoured only in IDLE
//   kd_in, inv_in       mode (0=Kyber/1=Dilithium, 0=NTT/1=INTT), latched on start
//   stall               holds pair issue while high (RUN only)
//   busy, done          pass in progress / one-cycle completion pulse
//   KD_mode, sel_1      latched kd_in / inv_in, to PE2
//   sel_0               high while the final stage is being issued
//   rd_en, rd_addr0/1   pair read strobe and operand addresses
//   wr_en, wr_addr0/1   write-back strobe and addresses (reads delayed by PIPE_LAT)
//   cycle_cnt           busy-cycle count (only with PE2_STAGE_CTRL_CYCLE_CNT_EN)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing pairs of stage s
// DRAIN | waiting PIPE_LAT cycles for the stage's writes to land
// FIN   | pulsing done, then back to IDLE

module pe2_stage_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int PAIRS    = 128,
  parameter int K_STAGES = 7,
  parameter int D_STAGES = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              kd_in,
  input  logic              inv_in,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              KD_mode,
  output logic              sel_1,
  output logic              sel_0,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr0,
  output logic [ADDR_W-1:0] wr_addr1
`ifdef PE2_STAGE_CTRL_CYCLE_CNT_EN
  ,
  output logic [15:0]       cycle_cnt
`endif
);

  localparam int JW = ADDR_W - 1;
  localparam int SW = $clog2((D_STAGES > K_STAGES) ? D_STAGES : K_STAGES);
  localparam int LW = $clog2(ADDR_W);
  localparam int DW = 3;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t            state;
  logic [JW-1:0]     j;
  logic [SW-1:0]     s;
  logic [DW-1:0]     dcnt;
  logic              last_stage;
  logic [LW-1:0]     lg;
  logic [ADDR_W-1:0] j_ext;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] addr0_nxt;
  logic [ADDR_W-1:0] addr1_nxt;

  logic [PIPE_LAT-1:0] pv;
  logic [ADDR_W-1:0]   pa0 [PIPE_LAT];
  logic [ADDR_W-1:0]   pa1 [PIPE_LAT];

  assign last_stage = KD_mode ? (s == SW'(D_STAGES - 1)) : (s == SW'(K_STAGES - 1));

  // log2 of the butterfly stride for the current stage.
  always_comb begin
    lg = '0;
    if (!sel_1)
      lg = LW'(ADDR_W - 1) - LW'(s);
    else
      lg = LW'(s) + (KD_mode ? LW'(0) : LW'(1));
  end

  // Pair j sits in block j/len; each block spans 2*len words, upper half
  // starts at the block base plus the offset inside the block.
  always_comb begin
    j_ext     = ADDR_W'(j);
    len       = ADDR_W'(1) << lg;
    addr0_nxt = (((j_ext >> lg) << lg) << 1) | (j_ext & (len - ADDR_W'(1)));
    addr1_nxt = addr0_nxt + len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      j        <= '0;
      s        <= '0;
      dcnt     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      KD_mode  <= 1'b0;
      sel_1    <= 1'b0;
      sel_0    <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr0 <= '0;
      rd_addr1 <= '0;
`ifdef PE2_STAGE_CTRL_CYCLE_CNT_EN
      cycle_cnt <= '0;
`endif
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;
`ifdef PE2_STAGE_CTRL_CYCLE_CNT_EN
      // Counts the RUN..FIN cycles, so it stops on the done cycle and holds.
      if (state != IDLE)
        cycle_cnt <= cycle_cnt + 16'd1;
`endif
      case (state)
        IDLE: begin
          busy  <= 1'b0;
          sel_0 <= 1'b0;
          if (start) begin
            KD_mode <= kd_in;
            sel_1   <= inv_in;
            s       <= '0;
            j       <= '0;
            busy    <= 1'b1;
            state   <= RUN;
`ifdef PE2_STAGE_CTRL_CYCLE_CNT_EN
            cycle_cnt <= '0;
`endif
          end
        end
        RUN: begin
          sel_0 <= last_stage;
          if (!stall) begin
            rd_en    <= 1'b1;
            rd_addr0 <= addr0_nxt;
            rd_addr1 <= addr1_nxt;
            j        <= j + JW'(1);
            if (j == JW'(PAIRS - 1)) begin
              dcnt  <= '0;
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          sel_0 <= 1'b0;
          if (dcnt == DW'(PIPE_LAT - 1)) begin
            if (last_stage) begin
              state <= FIN;
            end else begin
              s     <= s + SW'(1);
              j     <= '0;
              state <= RUN;
            end
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write-back delay line: shifts every cycle, stall does not freeze PE2.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        pa0[i] <= '0;
        pa1[i] <= '0;
      end
    end else begin
      pv[0]  <= rd_en;
      pa0[0] <= rd_addr0;
      pa1[0] <= rd_addr1;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pv[i]  <= pv[i-1];
        pa0[i] <= pa0[i-1];
        pa1[i] <= pa1[i-1];
      end
    end
  end

  assign wr_en    = pv[PIPE_LAT-1];
  assign wr_addr0 = pa0[PIPE_LAT-1];
  assign wr_addr1 = pa1[PIPE_LAT-1];

endmodule
